// File: rtl/uart_cmd_parser_pkg.sv
// Shared types and constants for the UART command framer: FSM state encoding,
// default header bytes and payload widths.
package uart_cmd_pkg;

    localparam int unsigned CMD_W   = 8;
    localparam int unsigned PARAM_W = 16;

    localparam logic [7:0] HEAD0_DEF = 8'h55;
    localparam logic [7:0] HEAD1_DEF = 8'hAA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_H1,
        S_CMD,
        S_PH,
        S_PL,
        S_CS
    } state_e;

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / command-out bundle between the RS232 receiver, the framer and the
// control logic. master = byte source and command sink, slave = the framer.
interface uart_cmd_parser_if
    import uart_cmd_pkg::*;
();

    logic [7:0]         rs232_rx_data;
    logic               rs232_rx_flag;
    logic               cmd_valid;
    logic [CMD_W-1:0]   cmd_code;
    logic [PARAM_W-1:0] cmd_param;
    logic               frame_err;

    modport master (
        output rs232_rx_data,
        output rs232_rx_flag,
        input  cmd_valid,
        input  cmd_code,
        input  cmd_param,
        input  frame_err
    );

    modport slave (
        input  rs232_rx_data,
        input  rs232_rx_flag,
        output cmd_valid,
        output cmd_code,
        output cmd_param,
        output frame_err
    );

endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap counter: cleared by each byte, held at zero while not running,
// flags expiry once the count reaches TO_CYC-1.
module uart_gap_timer #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int unsigned TO_CYC = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned CNT_W  = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TO_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr || !run) begin
            cnt_d = '0;
        end else if (cnt_q != TERM) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == TERM);

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames HEAD0 HEAD1 CMD PH PL [CS] out of the RS232 byte stream and emits verified
// commands. Define UART_CMD_CKSUM_EN to require and check the trailing checksum byte.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter logic [7:0]  HEAD0      = HEAD0_DEF,
    parameter logic [7:0]  HEAD1      = HEAD1_DEF
) (
    input logic              sys_clk,
    input logic              sys_rst_n,
    uart_cmd_parser_if.slave rx_cmd_io
);

    state_e             state_q, state_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [7:0]         ph_q, ph_d;
    logic [CMD_W-1:0]   cmd_code_q, cmd_code_d;
    logic [PARAM_W-1:0] cmd_param_q, cmd_param_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               frame_err_q, frame_err_d;
`ifdef UART_CMD_CKSUM_EN
    logic [7:0]         pl_q, pl_d;
    logic [7:0]         sum_q, sum_d;
`endif

    logic       flag;
    logic [7:0] b;
    logic       expired;

    assign flag = rx_cmd_io.rs232_rx_flag;
    assign b    = rx_cmd_io.rs232_rx_data;

    uart_gap_timer #(
        .CLK_FREQ   (CLK_FREQ),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_gap_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (flag),
        .run       (state_q != S_IDLE),
        .expired   (expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        ph_d        = ph_q;
        cmd_code_d  = cmd_code_q;
        cmd_param_d = cmd_param_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_CMD_CKSUM_EN
        pl_d        = pl_q;
        sum_d       = sum_q;
`endif
        // A byte arriving on the timeout terminal count takes priority over the timeout.
        if (flag) begin
            case (state_q)
                S_IDLE: begin
                    if (b == HEAD0) state_d = S_H1;
                end
                S_H1: begin
                    if (b == HEAD1)      state_d = S_CMD;
                    else if (b == HEAD0) state_d = S_H1;
                    else                 state_d = S_IDLE;
                end
                S_CMD: begin
                    cmd_d   = b;
                    state_d = S_PH;
`ifdef UART_CMD_CKSUM_EN
                    sum_d   = b;
`endif
                end
                S_PH: begin
                    ph_d    = b;
                    state_d = S_PL;
`ifdef UART_CMD_CKSUM_EN
                    sum_d   = sum_q + b;
`endif
                end
`ifdef UART_CMD_CKSUM_EN
                S_PL: begin
                    pl_d    = b;
                    sum_d   = sum_q + b;
                    state_d = S_CS;
                end
                S_CS: begin
                    if (b == sum_q) begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = cmd_q;
                        cmd_param_d = {ph_q, pl_q};
                    end else begin
                        frame_err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
`else
                S_PL: begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = cmd_q;
                    cmd_param_d = {ph_q, b};
                    state_d     = S_IDLE;
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end else if (expired) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            ph_q        <= '0;
            cmd_code_q  <= '0;
            cmd_param_q <= '0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_CMD_CKSUM_EN
            pl_q        <= '0;
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            ph_q        <= ph_d;
            cmd_code_q  <= cmd_code_d;
            cmd_param_q <= cmd_param_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_CMD_CKSUM_EN
            pl_q        <= pl_d;
            sum_q       <= sum_d;
`endif
        end
    end

    assign rx_cmd_io.cmd_valid = cmd_valid_q;
    assign rx_cmd_io.cmd_code  = cmd_code_q;
    assign rx_cmd_io.cmd_param = cmd_param_q;
    assign rx_cmd_io.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a strobe scoreboard; works with or
// without UART_CMD_CKSUM_EN. A short timeout keeps the gap tests fast.
module tb_uart_cmd_parser;
    import uart_cmd_pkg::*;

    localparam int unsigned CLK_FREQ   = 2_000_000;
    localparam int unsigned TIMEOUT_US = 500;
    localparam int unsigned TO_CYC     = 1000;

    typedef struct packed {
        logic        is_err;
        logic [7:0]  code;
        logic [15:0] param;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_parser_if bus ();

    uart_cmd_parser #(
        .CLK_FREQ   (CLK_FREQ),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .rx_cmd_io (bus)
    );

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [7:0]  held_code = 8'h00;
    logic [15:0] held_param = 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_valid(input logic [7:0] c, input logic [15:0] p);
        held_code  = c;
        held_param = p;
        sb.push_back('{is_err: 1'b0, code: c, param: p});
    endtask

    task automatic expect_err();
        sb.push_back('{is_err: 1'b1, code: held_code, param: held_param});
    endtask

    // Called on a negedge; returns on the next negedge so calls chain back-to-back.
    task automatic send_byte(input logic [7:0] v);
        bus.rs232_rx_data = v;
        bus.rs232_rx_flag = 1'b1;
        @(negedge clk);
        bus.rs232_rx_flag = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] ph, input logic [7:0] pl,
                              input logic [7:0] cs);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(c);
        send_byte(ph);
        send_byte(pl);
`ifdef UART_CMD_CKSUM_EN
        send_byte(cs);
`endif
    endtask

    // Every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && (bus.cmd_valid || bus.frame_err)) begin
            exp_t e;
            check("strobe_exclusive", {31'b0, bus.cmd_valid & bus.frame_err}, 32'd0);
            check("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("strobe_kind", {31'b0, bus.frame_err}, {31'b0, e.is_err});
                check("strobe_code", {24'b0, bus.cmd_code}, {24'b0, e.code});
                check("strobe_param", {16'b0, bus.cmd_param}, {16'b0, e.param});
            end
        end
    end

    initial begin
        int n;
        bus.rs232_rx_data = 8'h00;
        bus.rs232_rx_flag = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'b0, bus.cmd_valid}, 32'd0);
        check("rst_err", {31'b0, bus.frame_err}, 32'd0);
        check("rst_code", {24'b0, bus.cmd_code}, 32'h00);
        check("rst_param", {16'b0, bus.cmd_param}, 32'h0000);
        rst_n = 1'b1;
        @(negedge clk);

        // Good frame, then a header-valued payload frame starting while cmd_valid is high
        expect_valid(8'h10, 16'h1234);
        send_frame(8'h10, 8'h12, 8'h34, 8'h56);
        check("t1_latency", {31'b0, bus.cmd_valid}, 32'd1);
        check("t1_code", {24'b0, bus.cmd_code}, 32'h10);
        check("t1_param", {16'b0, bus.cmd_param}, 32'h1234);
        expect_valid(8'h55, 16'hAA55);
        send_frame(8'h55, 8'hAA, 8'h55, 8'h54);
        check("t1b_latency", {31'b0, bus.cmd_valid}, 32'd1);

        // Bad checksum
`ifdef UART_CMD_CKSUM_EN
        expect_err();
        send_frame(8'h10, 8'h12, 8'h34, 8'h57);
        check("t2_err", {31'b0, bus.frame_err}, 32'd1);
        check("t2_no_valid", {31'b0, bus.cmd_valid}, 32'd0);
        check("t2_code_held", {24'b0, bus.cmd_code}, 32'h55);
        check("t2_param_held", {16'b0, bus.cmd_param}, 32'hAA55);
`else
        expect_valid(8'h10, 16'h1234);
        send_frame(8'h10, 8'h12, 8'h34, 8'h57);
        check("t2_valid", {31'b0, bus.cmd_valid}, 32'd1);
        send_byte(8'h57);
`endif

        // Repeated HEAD0 and checksum wrap
        expect_valid(8'h01, 16'h00FF);
        send_byte(8'h55);
        send_frame(8'h01, 8'h00, 8'hFF, 8'h00);
        check("t3_latency", {31'b0, bus.cmd_valid}, 32'd1);
        check("t3_param", {16'b0, bus.cmd_param}, 32'h00FF);

        // Timeout after partial frame
        expect_err();
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h10);
        n = 0;
        while (!bus.frame_err && n < int'(TO_CYC) + 20) begin
            @(negedge clk);
            n++;
        end
        check("t4_gap_clks", 32'(n), TO_CYC);
        check("t4_code_held", {24'b0, bus.cmd_code}, 32'h01);
        @(negedge clk);
        expect_valid(8'h20, 16'h0001);
        send_frame(8'h20, 8'h00, 8'h01, 8'h21);
        check("t4_recover", {31'b0, bus.cmd_valid}, 32'd1);

        // Byte lands exactly on the terminal count
        expect_valid(8'h30, 16'h1234);
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h30);
        repeat (TO_CYC - 1) @(negedge clk);
        send_byte(8'h12);
        check("t5_no_err", {31'b0, bus.frame_err}, 32'd0);
        send_byte(8'h34);
`ifdef UART_CMD_CKSUM_EN
        send_byte(8'h76);
`endif
        check("t5_valid", {31'b0, bus.cmd_valid}, 32'd1);

        // Reset mid-frame
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h10);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_rst_code", {24'b0, bus.cmd_code}, 32'h00);
        check("t5_rst_param", {16'b0, bus.cmd_param}, 32'h0000);
        check("t5_rst_valid", {31'b0, bus.cmd_valid}, 32'd0);
        rst_n = 1'b1;
        held_code  = 8'h00;
        held_param = 16'h0000;
        @(negedge clk);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        repeat (4) @(negedge clk);

        // Trailing byte after a frame starts a fresh search
        expect_valid(8'h7F, 16'hABCD);
        send_frame(8'h7F, 8'hAB, 8'hCD, 8'hF7);
        check("t6_code", {24'b0, bus.cmd_code}, 32'h7F);
        check("t6_param", {16'b0, bus.cmd_param}, 32'hABCD);
        send_byte(8'hAA);
        expect_valid(8'h01, 16'h0203);
        send_frame(8'h01, 8'h02, 8'h03, 8'h06);
        check("t6_next", {31'b0, bus.cmd_valid}, 32'd1);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
